// File: rtl/pit_pkg.sv
// ---------------------------------------------------------------------------
// pit_pkg
// Shared definitions for the multi-channel programmable interval timer:
// register offsets, CTRL bit positions, channel stride, legal parameter
// ranges, AXI response code and the AXI-Lite FSM state types.
// ---------------------------------------------------------------------------
package pit_pkg;

  // Legal parameter ranges
  localparam int NUM_CH_MIN = 1;
  localparam int NUM_CH_MAX = 8;
  localparam int CNT_W_MIN  = 8;
  localparam int CNT_W_MAX  = 32;

  // Global registers
  localparam logic [31:0] REG_IRQ_STATUS = 32'h00;
  localparam logic [31:0] REG_INFO       = 32'h04;
  localparam logic [31:0] REG_PRESCALE   = 32'h08;

  // Channel register block: base + stride * channel + offset
  localparam logic [31:0] CH_BASE   = 32'h10;
  localparam logic [31:0] CH_STRIDE = 32'h10;
  localparam logic [31:0] CH_CTRL   = 32'h0;
  localparam logic [31:0] CH_PERIOD = 32'h4;
  localparam logic [31:0] CH_COUNT  = 32'h8;

  // CTRL bit indices
  localparam int CTRL_RUN      = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_PERIODIC = 2;
  localparam int CTRL_CLEAR    = 3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;

  // Byte address of register 'off' inside channel 'ch'
  function automatic logic [31:0] ch_reg_addr(input int ch, input logic [31:0] off);
    return CH_BASE + CH_STRIDE * 32'(ch) + off;
  endfunction

endpackage

// File: rtl/pit_multi_if.sv
// ---------------------------------------------------------------------------
// pit_multi_if
// AXI4-Lite bundle (32-bit data, 4-bit strobe) for the timer register port.
//   master : drives aw/w/ar payload + valid, bready, rready
//   slave  : drives awready, wready, b/r response, arready
// ---------------------------------------------------------------------------
interface pit_multi_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/pit_channel.sv
// ---------------------------------------------------------------------------
// pit_channel
// One timer channel: CTRL bits, PERIOD, COUNT and the expiry pulse.
//   aclk, aresetn  clock / async active-low reset
//   tick_i         shared prescaler tick
//   wr_ctrl_i      write strobe for this channel's CTRL
//   wr_period_i    write strobe for this channel's PERIOD
//   wdata_i/wstrb_i write data and byte strobes
//   ctrl_o, period_o, count_o  32-bit read-back values
//   run_o, irq_en_o            live control bits
//   expire_o       high in the cycle whose rising edge expires the channel
// ---------------------------------------------------------------------------
module pit_channel
  import pit_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        tick_i,
  input  logic        wr_ctrl_i,
  input  logic        wr_period_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  output logic [31:0] ctrl_o,
  output logic [31:0] period_o,
  output logic [31:0] count_o,
  output logic        run_o,
  output logic        irq_en_o,
  output logic        expire_o
);

  logic             run_q, run_d;
  logic             irq_en_q, irq_en_d;
  logic             periodic_q, periodic_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      period_w;

  always_comb begin
    run_d      = run_q;
    irq_en_d   = irq_en_q;
    periodic_d = periodic_q;
    period_d   = period_q;
    count_d    = count_q;
    expire_o   = 1'b0;
    period_w   = 32'(period_q);

    if (tick_i && run_q) begin
      if (period_q == '0) begin
        // PERIOD=0 parks the counter and never expires
        count_d = '0;
      end else if (count_q >= period_q - CNT_W'(1)) begin
        // >= so that shrinking PERIOD below COUNT expires on the next tick
        expire_o = 1'b1;
        count_d  = '0;
        if (!periodic_q) begin
          run_d = 1'b0;
        end
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end

    // A register write on the same edge as a tick overrides the tick's
    // effect on the written fields.
    if (wr_ctrl_i && wstrb_i[0]) begin
      run_d      = wdata_i[CTRL_RUN];
      irq_en_d   = wdata_i[CTRL_IRQ_EN];
      periodic_d = wdata_i[CTRL_PERIODIC];
      if (wdata_i[CTRL_CLEAR]) begin
        count_d = '0;
      end
    end

    if (wr_period_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_i[b]) begin
          period_w[8*b +: 8] = wdata_i[8*b +: 8];
        end
      end
      period_d = period_w[CNT_W-1:0];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      periodic_q <= 1'b0;
      period_q   <= '0;
      count_q    <= '0;
    end else begin
      run_q      <= run_d;
      irq_en_q   <= irq_en_d;
      periodic_q <= periodic_d;
      period_q   <= period_d;
      count_q    <= count_d;
    end
  end

  // The clear bit is a command, so it always reads back as 0
  assign ctrl_o   = {29'd0, periodic_q, irq_en_q, run_q};
  assign period_o = 32'(period_q);
  assign count_o  = 32'(count_q);
  assign run_o    = run_q;
  assign irq_en_o = irq_en_q;

endmodule

// File: rtl/pit_multi.sv
// ---------------------------------------------------------------------------
// pit_multi
// Multi-channel programmable interval timer behind an AXI4-Lite slave.
// NUM_CH up-counters share one prescaler; expiries latch into a W1C
// IRQ_STATUS register that drives a single level interrupt.
//   aclk     clock
//   aresetn  asynchronous active-low reset
//   s_axi    AXI4-Lite slave port (pit_multi_if.slave)
//   irq      |(IRQ_STATUS & per-channel irq_en)
// ---------------------------------------------------------------------------
module pit_multi
  import pit_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 8
) (
  input  logic        aclk,
  input  logic        aresetn,
  pit_multi_if.slave  s_axi,
  output logic        irq
);

  if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX ||
      CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_param_check
    $error("pit_multi: NUM_CH or CNT_W out of range");
  end

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic              awready, wready, bvalid, arready, rvalid;
  logic              wr_fire;
  logic [31:0]       wr_addr, rd_addr;
  logic [31:0]       rdata_q, rdata_d, rd_mux;
  logic [15:0]       prescale_q, prescale_d;
  logic [15:0]       presc_cnt_q, presc_cnt_d;
  logic [NUM_CH-1:0] status_q, status_d;
  logic              any_run, tick;

  logic [31:0]       ch_ctrl   [NUM_CH];
  logic [31:0]       ch_period [NUM_CH];
  logic [31:0]       ch_count  [NUM_CH];
  logic [NUM_CH-1:0] ch_run, ch_irq_en, ch_expire;

  // Address bits [1:0] are ignored
  assign wr_addr = 32'({s_axi.awaddr[ADDR_W-1:2], 2'b00});
  assign rd_addr = 32'({s_axi.araddr[ADDR_W-1:2], 2'b00});

  // ---------------- write channel FSM ----------------
  always_comb begin
    wr_state_d = wr_state_q;
    awready    = 1'b0;
    wready     = 1'b0;
    bvalid     = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        if (s_axi.awvalid && s_axi.wvalid) begin
          awready    = 1'b1;
          wready     = 1'b1;
          wr_state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        bvalid = 1'b1;
        if (s_axi.bready) begin
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  assign wr_fire = awready;

  // ---------------- read channel FSM ----------------
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    arready    = 1'b0;
    rvalid     = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if (s_axi.arvalid) begin
          arready    = 1'b1;
          rdata_d    = rd_mux;
          rd_state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        rvalid = 1'b1;
        if (s_axi.rready) begin
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
    end
  end

  assign s_axi.awready = awready;
  assign s_axi.wready  = wready;
  assign s_axi.bvalid  = bvalid;
  assign s_axi.bresp   = RESP_OKAY;
  assign s_axi.arready = arready;
  assign s_axi.rvalid  = rvalid;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = RESP_OKAY;

  // ---------------- read mux (registered values only) ----------------
  always_comb begin
    rd_mux = '0;
    if (rd_addr == REG_IRQ_STATUS) rd_mux = 32'(status_q);
    if (rd_addr == REG_INFO)       rd_mux = {16'h0, 8'(CNT_W), 8'(NUM_CH)};
    if (rd_addr == REG_PRESCALE)   rd_mux = {16'h0, prescale_q};
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_addr == ch_reg_addr(c, CH_CTRL))   rd_mux = ch_ctrl[c];
      if (rd_addr == ch_reg_addr(c, CH_PERIOD)) rd_mux = ch_period[c];
      if (rd_addr == ch_reg_addr(c, CH_COUNT))  rd_mux = ch_count[c];
    end
  end

  // ---------------- prescaler, PRESCALE and IRQ_STATUS ----------------
  assign any_run = |ch_run;
  // >= lets a shrunken PRESCALE take effect without a counter wrap
  assign tick    = any_run && (presc_cnt_q >= prescale_q);

  always_comb begin
    presc_cnt_d = presc_cnt_q;
    prescale_d  = prescale_q;
    status_d    = status_q;

    if (any_run) begin
      presc_cnt_d = tick ? 16'd0 : presc_cnt_q + 16'd1;
    end

    if (wr_fire && wr_addr == REG_PRESCALE) begin
      if (s_axi.wstrb[0]) prescale_d[7:0]  = s_axi.wdata[7:0];
      if (s_axi.wstrb[1]) prescale_d[15:8] = s_axi.wdata[15:8];
    end

    if (wr_fire && wr_addr == REG_IRQ_STATUS && s_axi.wstrb[0]) begin
      status_d = status_q & ~s_axi.wdata[NUM_CH-1:0];
    end
    // Expiry is applied after the clear so a coincident set wins
    status_d = status_d | ch_expire;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdata_q     <= '0;
      prescale_q  <= '0;
      presc_cnt_q <= '0;
      status_q    <= '0;
    end else begin
      rdata_q     <= rdata_d;
      prescale_q  <= prescale_d;
      presc_cnt_q <= presc_cnt_d;
      status_q    <= status_d;
    end
  end

  assign irq = |(status_q & ch_irq_en);

  // ---------------- channels ----------------
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    pit_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .tick_i      (tick),
      .wr_ctrl_i   (wr_fire && (wr_addr == ch_reg_addr(gi, CH_CTRL))),
      .wr_period_i (wr_fire && (wr_addr == ch_reg_addr(gi, CH_PERIOD))),
      .wdata_i     (s_axi.wdata),
      .wstrb_i     (s_axi.wstrb),
      .ctrl_o      (ch_ctrl[gi]),
      .period_o    (ch_period[gi]),
      .count_o     (ch_count[gi]),
      .run_o       (ch_run[gi]),
      .irq_en_o    (ch_irq_en[gi]),
      .expire_o    (ch_expire[gi])
    );
  end

endmodule

// File: tb/tb_pit_multi.sv
// ---------------------------------------------------------------------------
// tb_pit_multi
// Self-checking bench for pit_multi: directed scenarios plus a randomized
// register-traffic phase, compared against a behavioural timer model.
// ---------------------------------------------------------------------------
module tb_pit_multi;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;
  localparam int ADDR_W = 8;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  logic irq;

  pit_multi_if #(.ADDR_W(ADDR_W)) axi ();

  pit_multi #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_axi   (axi.slave),
    .irq     (irq)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned m_prescale, m_pcnt, m_status;
  int unsigned m_period [NUM_CH];
  int unsigned m_count  [NUM_CH];
  bit          m_run    [NUM_CH];
  bit          m_ien    [NUM_CH];
  bit          m_per    [NUM_CH];

  function automatic void model_reset();
    m_prescale = 0; m_pcnt = 0; m_status = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_period[c] = 0; m_count[c] = 0; m_run[c] = 0; m_ien[c] = 0; m_per[c] = 0;
    end
  endfunction

  function automatic bit model_any_run();
    bit r = 0;
    for (int c = 0; c < NUM_CH; c++) r |= m_run[c];
    return r;
  endfunction

  function automatic bit model_tick();
    return model_any_run() && (m_pcnt >= m_prescale);
  endfunction

  function automatic bit model_expires_next(input int c);
    return model_tick() && m_run[c] && m_period[c] != 0 && m_count[c] >= m_period[c] - 1;
  endfunction

  function automatic bit model_irq();
    bit r = 0;
    for (int c = 0; c < NUM_CH; c++) r |= m_ien[c] && m_status[c];
    return r;
  endfunction

  function automatic int unsigned merge_bytes(input int unsigned old, input logic [31:0] data,
                                              input logic [3:0] strb, input int nbytes);
    logic [31:0] r = old;
    for (int b = 0; b < nbytes; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  // Advance the model across one rising edge, with an optional register write
  function automatic void model_edge(input bit wr, input logic [31:0] addr,
                                     input logic [31:0] data, input logic [3:0] strb);
    bit          tick = model_tick();
    int unsigned expired = 0;
    logic [31:0] a = addr & 32'hFFFF_FFFC;
    if (model_any_run()) m_pcnt = tick ? 0 : m_pcnt + 1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (tick && m_run[c]) begin
        if (m_period[c] == 0) m_count[c] = 0;
        else if (m_count[c] >= m_period[c] - 1) begin
          m_count[c] = 0;
          expired |= (1 << c);
          if (!m_per[c]) m_run[c] = 0;
        end else m_count[c] = m_count[c] + 1;
      end
    end
    if (wr) begin
      if (a == 0 && strb[0]) m_status &= ~(data & ((1 << NUM_CH) - 1));
      if (a == 8) m_prescale = merge_bytes(m_prescale, data, strb, 2);
      for (int c = 0; c < NUM_CH; c++) begin
        if (a == 16 + 16*c && strb[0]) begin
          m_run[c] = data[0]; m_ien[c] = data[1]; m_per[c] = data[2];
          if (data[3]) m_count[c] = 0;
        end
        if (a == 16 + 16*c + 4) m_period[c] = merge_bytes(m_period[c], data, strb, 4);
      end
    end
    m_status |= expired;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    logic [31:0] a = addr & 32'hFFFF_FFFC;
    int unsigned c, off;
    if (a == 0) return m_status;
    if (a == 4) return 32'h0000_2004;
    if (a == 8) return m_prescale;
    if (a >= 16 && a < 16 + 16*NUM_CH) begin
      c = (a - 16) / 16;
      off = (a - 16) % 16;
      case (off)
        0: return {29'd0, m_per[c], m_ien[c], m_run[c]};
        4: return m_period[c];
        8: return m_count[c];
        default: return 0;
      endcase
    end
    return 0;
  endfunction

  // ---------------- bus driving (called at a falling edge) ----------------
  task automatic step(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb);
    @(posedge aclk);
    model_edge(wr, addr, data, strb);
    @(negedge aclk);
    check("irq", 32'(irq), 32'(model_irq()));
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    axi.awaddr  = addr[ADDR_W-1:0];
    axi.wdata   = data;
    axi.wstrb   = strb;
    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b1;
    axi.bready  = 1'b0;
    #1;
    check("awready", 32'(axi.awready), 32'd1);
    check("wready", 32'(axi.wready), 32'd1);
    step(1'b1, addr, data, strb);
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b1;
    #1;
    check("bvalid", 32'(axi.bvalid), 32'd1);
    check("bresp", 32'(axi.bresp), 32'd0);
    step(1'b0, 32'h0, 32'h0, 4'h0);
    axi.bready = 1'b0;
    $display("WR addr=0x%02h data=0x%08h strb=0x%h", addr[7:0], data, strb);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
    logic [31:0] exp;
    axi.araddr  = addr[ADDR_W-1:0];
    axi.arvalid = 1'b1;
    axi.rready  = 1'b0;
    #1;
    check("arready", 32'(axi.arready), 32'd1);
    exp = model_read(addr);
    step(1'b0, 32'h0, 32'h0, 4'h0);
    axi.arvalid = 1'b0;
    axi.rready  = 1'b1;
    #1;
    check("rvalid", 32'(axi.rvalid), 32'd1);
    check("rresp", 32'(axi.rresp), 32'd0);
    check($sformatf("rdata@%02h", addr[7:0]), axi.rdata, exp);
    data = axi.rdata;
    step(1'b0, 32'h0, 32'h0, 4'h0);
    axi.rready = 1'b0;
    $display("RD addr=0x%02h data=0x%08h", addr[7:0], data);
  endtask

  task automatic wait_count(input int c, input int unsigned v, input int budget);
    int n = 0;
    while (m_count[c] != v && n < budget) begin
      idle(1);
      n++;
    end
    check($sformatf("wait_count%0d", c), 32'(m_count[c]), v);
  endtask

  task automatic wait_expiry(input int c, input int budget);
    int n = 0;
    while (!model_expires_next(c) && n < budget) begin
      idle(1);
      n++;
    end
    check($sformatf("wait_expiry%0d", c), 32'(model_expires_next(c)), 32'd1);
  endtask

  task automatic read_all();
    logic [31:0] d;
    axi_read(32'h0, d);
    axi_read(32'h4, d);
    axi_read(32'h8, d);
    for (int c = 0; c < NUM_CH; c++) begin
      axi_read(32'(16 + 16*c), d);
      axi_read(32'(16 + 16*c + 4), d);
      axi_read(32'(16 + 16*c + 8), d);
    end
  endtask

  // Watchdog: the run must never hang
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] a, wd;
    logic [3:0]  st;
    int          sel, c;

    axi.awaddr = '0; axi.awvalid = 0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 0;
    axi.bready = 0; axi.araddr = '0; axi.arvalid = 0; axi.rready = 0;
    model_reset();
    repeat (3) @(negedge aclk);

    // Reset state
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_awready", 32'(axi.awready), 32'd0);
    check("rst_bvalid", 32'(axi.bvalid), 32'd0);
    check("rst_arready", 32'(axi.arready), 32'd0);
    check("rst_rvalid", 32'(axi.rvalid), 32'd0);
    check("rst_rdata", axi.rdata, 32'd0);
    aresetn = 1'b1;
    idle(2);

    axi_read(32'h4, d);
    check("info", d, 32'h0000_2004);
    read_all();

    // Ch0 periodic, period 4, prescale 0
    axi_write(32'h08, 32'h0, 4'hF);
    axi_write(32'h14, 32'h4, 4'hF);
    axi_write(32'h10, 32'h7, 4'hF);
    idle(12);
    axi_read(32'h0, d);
    axi_write(32'h00, 32'h1, 4'hF);
    idle(6);

    // Ch1 one-shot: exactly one expiry
    axi_write(32'h24, 32'h3, 4'hF);
    axi_write(32'h20, 32'h3, 4'hF);
    idle(10);
    axi_read(32'h20, d);
    check("oneshot_ctrl", d, 32'h2);
    axi_read(32'h28, d);
    check("oneshot_count", d, 32'h0);
    axi_write(32'h00, 32'h2, 4'hF);
    idle(10);
    axi_read(32'h00, d);
    check("oneshot_once", 32'(d[1]), 32'd0);

    // Ch0 pause at COUNT=2, then resume
    wait_count(0, 1, 20);
    axi_write(32'h10, 32'h6, 4'hF);
    idle(20);
    axi_read(32'h18, d);
    check("pause_count", d, 32'h2);
    axi_write(32'h00, 32'h1, 4'hF);
    axi_write(32'h10, 32'h7, 4'hF);
    axi_read(32'h00, d);
    check("resume_early", 32'(d[0]), 32'd0);
    axi_read(32'h00, d);
    check("resume_expire", 32'(d[0]), 32'd1);

    // Ch2 with prescaler, irq masked, set-wins-over-clear
    axi_write(32'h10, 32'h0, 4'hF);
    axi_write(32'h00, 32'hF, 4'hF);
    axi_write(32'h08, 32'h3, 4'hF);
    axi_write(32'h34, 32'h2, 4'hF);
    axi_write(32'h30, 32'h5, 4'hF);
    idle(20);
    axi_read(32'h00, d);
    check("ch2_status", 32'(d[2]), 32'd1);
    check("ch2_masked", 32'(irq), 32'd0);
    axi_write(32'h00, 32'h4, 4'hF);
    wait_expiry(2, 40);
    axi_write(32'h00, 32'h4, 4'hF);
    axi_read(32'h00, d);
    check("set_wins", 32'(d[2]), 32'd1);

    // Ch3: shrink PERIOD below COUNT
    axi_write(32'h30, 32'h0, 4'hF);
    axi_write(32'h08, 32'h0, 4'hF);
    axi_write(32'h44, 32'd100, 4'hF);
    axi_write(32'h40, 32'h5, 4'hF);
    wait_count(3, 49, 200);
    axi_write(32'h44, 32'd10, 4'hF);
    axi_read(32'h00, d);
    check("shrink_expire", 32'(d[3]), 32'd1);
    axi_read(32'h48, d);

    // Unmapped / read-only writes are ignored and reads return 0
    axi_write(32'hF0, 32'h08, 4'hF);
    axi_write(32'h4C, 32'h08, 4'hF);
    axi_write(32'h04, 32'hFFFF_FFFF, 4'hF);
    axi_read(32'hF0, d);
    check("unmapped_f0", d, 32'h0);
    axi_read(32'h4C, d);
    check("unmapped_4c", d, 32'h0);
    axi_read(32'h04, d);
    check("info_ro", d, 32'h0000_2004);

    // Randomized register traffic
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 9);
      c   = $urandom_range(0, NUM_CH - 1);
      st  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      if (sel < 6) begin
        case ($urandom_range(0, 9))
          0:       begin a = 32'h00; wd = $urandom_range(0, 15); end
          1:       begin a = 32'h08; wd = $urandom_range(0, 3); end
          2, 3:    begin a = 32'(16 + 16*c); wd = $urandom_range(0, 15); end
          4, 5:    begin a = 32'(16 + 16*c + 4); wd = $urandom_range(0, 12); end
          6:       begin a = 32'(16 + 16*c + 8); wd = $urandom; end
          7:       begin a = 32'h04; wd = $urandom; end
          default: begin a = 32'($urandom_range(20, 63) * 4); wd = $urandom; end
        endcase
        a = a | 32'($urandom_range(0, 3));
        axi_write(a, wd, st);
      end else if (sel < 9) begin
        if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(0, 63) * 4);
        else a = 32'(16 + 16*c + 4*$urandom_range(0, 2));
        axi_read(a | 32'($urandom_range(0, 3)), d);
      end else begin
        idle($urandom_range(1, 8));
      end
    end
    read_all();

    // Reset in the middle of a write response
    axi_write(32'h50, 32'h0, 4'hF);
    axi.awaddr = 8'h08; axi.wdata = 32'h5; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b0;
    step(1'b1, 32'h08, 32'h5, 4'hF);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    #1;
    check("pre_rst_bvalid", 32'(axi.bvalid), 32'd1);
    aresetn = 1'b0;
    #1;
    check("mid_rst_bvalid", 32'(axi.bvalid), 32'd0);
    check("mid_rst_irq", 32'(irq), 32'd0);
    model_reset();
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    idle(2);
    axi_read(32'h08, d);
    check("rst_prescale", d, 32'h0);
    read_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
